// File: rtl/controller_pkg.sv
// Shared types and defaults for the standby I2C front-end.
//   bus_state_e        : bus qualification state reported by standby_bus_monitor
//   DefaultCntWidth    : default width of bus timing thresholds / counter
//   DefaultGlitchWidth : default width of the glitch-filter threshold / counter
package controller_pkg;

  localparam int unsigned DefaultCntWidth    = 20;
  localparam int unsigned DefaultGlitchWidth = 8;

  typedef enum logic [2:0] {
    BusBusy      = 3'd0,
    BusWaitFree  = 3'd1,
    BusFree      = 3'd2,
    BusAvailable = 3'd3,
    BusIdle      = 3'd4
  } bus_state_e;

endpackage

// File: rtl/standby_bus_monitor_bus_line_filter.sv
// Two-flop synchroniser followed by a glitch filter for one bus line.
// The filtered output only follows the synchronised value after it has
// differed for max(t_glitch_i,1) consecutive cycles.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   line_i       : raw line from the PHY
//   t_glitch_i   : stable-cycles threshold (0 behaves as 1)
//   line_o       : filtered line (resets to 1, the idle bus level)
module bus_line_filter
  import controller_pkg::*;
#(
  parameter int unsigned GlitchWidth = DefaultGlitchWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   line_i,
  input  logic [GlitchWidth-1:0] t_glitch_i,
  output logic                   line_o
);

  logic                   sync_q1;
  logic                   sync_q2;
  logic                   filt_q;
  logic [GlitchWidth-1:0] cnt_q;
  logic [GlitchWidth-1:0] thresh;
  logic [GlitchWidth:0]   cnt_inc;

  assign thresh  = (t_glitch_i == '0) ? GlitchWidth'(1) : t_glitch_i;
  // One bit wider so the compare cannot wrap at the top of the range.
  assign cnt_inc = {1'b0, cnt_q} + (GlitchWidth + 1)'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= line_i;
      sync_q2 <= sync_q1;
      if (sync_q2 == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_inc >= {1'b0, thresh}) begin
        filt_q <= sync_q2;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_inc[GlitchWidth-1:0];
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/standby_bus_monitor.sv
// Front-end conditioner for the standby I2C target FSM.
// Synchronises and glitch-filters SCL/SDA, detects START / repeated START /
// STOP, and qualifies the bus as free / available / idle from timing CSRs.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   enable_i            : low holds the FSM in WAIT_FREE and suppresses conditions
//   scl_i, sda_i        : raw bus lines
//   t_glitch_i          : filter stable-cycles threshold
//   t_bus_free_i / t_bus_available_i / t_bus_idle_i : qualification thresholds
//   scl_o, sda_o        : filtered lines to the target FSM
//   scl_posedge_o/scl_negedge_o : filtered SCL edge pulses
//   start_det_o/rstart_det_o/stop_det_o : bus condition pulses
//   bus_state_o, bus_free_o, bus_available_o, bus_idle_o : bus state and flags
module standby_bus_monitor
  import controller_pkg::*;
#(
  parameter int unsigned CntWidth    = DefaultCntWidth,
  parameter int unsigned GlitchWidth = DefaultGlitchWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   scl_i,
  input  logic                   sda_i,
  input  logic [GlitchWidth-1:0] t_glitch_i,
  input  logic [CntWidth-1:0]    t_bus_free_i,
  input  logic [CntWidth-1:0]    t_bus_available_i,
  input  logic [CntWidth-1:0]    t_bus_idle_i,
  output logic                   scl_o,
  output logic                   sda_o,
  output logic                   scl_posedge_o,
  output logic                   scl_negedge_o,
  output logic                   start_det_o,
  output logic                   rstart_det_o,
  output logic                   stop_det_o,
  output logic [2:0]             bus_state_o,
  output logic                   bus_free_o,
  output logic                   bus_available_o,
  output logic                   bus_idle_o
);

  logic scl_filt;
  logic sda_filt;

  bus_line_filter #(
    .GlitchWidth(GlitchWidth)
  ) u_scl_filter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .line_i    (scl_i),
    .t_glitch_i(t_glitch_i),
    .line_o    (scl_filt)
  );

  bus_line_filter #(
    .GlitchWidth(GlitchWidth)
  ) u_sda_filter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .line_i    (sda_i),
    .t_glitch_i(t_glitch_i),
    .line_o    (sda_filt)
  );

  assign scl_o = scl_filt;
  assign sda_o = sda_filt;

  // ---------------------------------------------------------------------
  // Condition detection on previous/current filtered values
  // ---------------------------------------------------------------------
  logic scl_prev_q;
  logic sda_prev_q;
  logic scl_rise;
  logic scl_fall;
  logic start_cond;
  logic stop_cond;

  assign scl_rise = scl_filt & ~scl_prev_q;
  assign scl_fall = ~scl_filt & scl_prev_q;
  // SCL must be high in both samples, so a simultaneous SCL/SDA change
  // never qualifies as a bus condition.
  assign start_cond = scl_prev_q & scl_filt & sda_prev_q & ~sda_filt;
  assign stop_cond  = scl_prev_q & scl_filt & ~sda_prev_q & sda_filt;

  // ---------------------------------------------------------------------
  // Bus state FSM: state register
  // ---------------------------------------------------------------------
  bus_state_e          state_q;
  bus_state_e          state_d;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BusWaitFree;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Bus state FSM: next state and qualification counter
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable_i) begin
      state_d = BusWaitFree;
      cnt_d   = '0;
    end else if (start_cond) begin
      state_d = BusBusy;
      cnt_d   = '0;
    end else if (state_q == BusBusy) begin
      cnt_d = '0;
      if (stop_cond) begin
        state_d = BusWaitFree;
      end
    end else if (!scl_filt) begin
      // SCL low outside BUSY means we missed a START; assume a transfer.
      state_d = BusBusy;
      cnt_d   = '0;
    end else begin
      if (sda_filt && (cnt_q != '1)) begin
        cnt_d = cnt_q + CntWidth'(1);
      end
      // Thresholds are compared live; one step per cycle at most.
      unique case (state_q)
        BusWaitFree:  if (cnt_q >= t_bus_free_i)      state_d = BusFree;
        BusFree:      if (cnt_q >= t_bus_available_i) state_d = BusAvailable;
        BusAvailable: if (cnt_q >= t_bus_idle_i)      state_d = BusIdle;
        default:      state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Bus state FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus_state_o     = state_q;
    bus_free_o      = 1'b0;
    bus_available_o = 1'b0;
    bus_idle_o      = 1'b0;
    unique case (state_q)
      BusFree: begin
        bus_free_o = 1'b1;
      end
      BusAvailable: begin
        bus_free_o      = 1'b1;
        bus_available_o = 1'b1;
      end
      BusIdle: begin
        bus_free_o      = 1'b1;
        bus_available_o = 1'b1;
        bus_idle_o      = 1'b1;
      end
      default: begin
        bus_free_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registered pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      scl_posedge_o <= 1'b0;
      scl_negedge_o <= 1'b0;
      start_det_o   <= 1'b0;
      rstart_det_o  <= 1'b0;
      stop_det_o    <= 1'b0;
    end else begin
      scl_prev_q    <= scl_filt;
      sda_prev_q    <= sda_filt;
      scl_posedge_o <= scl_rise;
      scl_negedge_o <= scl_fall;
      start_det_o   <= enable_i & start_cond & (state_q != BusBusy);
      rstart_det_o  <= enable_i & start_cond & (state_q == BusBusy);
      stop_det_o    <= enable_i & stop_cond;
    end
  end

endmodule

// File: tb/tb_standby_bus_monitor.sv
module tb_standby_bus_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        scl;
  logic        sda;
  logic [7:0]  tg;
  logic [19:0] tf;
  logic [19:0] ta;
  logic [19:0] ti;
  logic        scl_o;
  logic        sda_o;
  logic        scl_posedge_o;
  logic        scl_negedge_o;
  logic        start_det_o;
  logic        rstart_det_o;
  logic        stop_det_o;
  logic [2:0]  bus_state_o;
  logic        bus_free_o;
  logic        bus_available_o;
  logic        bus_idle_o;

  localparam logic [31:0] SBusy  = 32'd0;
  localparam logic [31:0] SWait  = 32'd1;
  localparam logic [31:0] SFree  = 32'd2;
  localparam logic [31:0] SAvail = 32'd3;
  localparam logic [31:0] SIdle  = 32'd4;

  standby_bus_monitor #(
    .CntWidth(20),
    .GlitchWidth(8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (en),
    .scl_i            (scl),
    .sda_i            (sda),
    .t_glitch_i       (tg),
    .t_bus_free_i     (tf),
    .t_bus_available_i(ta),
    .t_bus_idle_i     (ti),
    .scl_o            (scl_o),
    .sda_o            (sda_o),
    .scl_posedge_o    (scl_posedge_o),
    .scl_negedge_o    (scl_negedge_o),
    .start_det_o      (start_det_o),
    .rstart_det_o     (rstart_det_o),
    .stop_det_o       (stop_det_o),
    .bus_state_o      (bus_state_o),
    .bus_free_o       (bus_free_o),
    .bus_available_o  (bus_available_o),
    .bus_idle_o       (bus_idle_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: expectation pushed with its name, popped when observed.
  logic [31:0] sb_exp[$];
  string       sb_name[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    tg = 8'd1; tf = 20'd10; ta = 20'd20; ti = 20'd30; en = 1'b1;
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    tick();
    sb_exp.push_back(32'd1); sb_name.push_back("rst_scl_o");
    sb_exp.push_back(32'd1); sb_name.push_back("rst_sda_o");
    sb_exp.push_back(32'd0); sb_name.push_back("rst_pulses");
    sb_exp.push_back(SWait); sb_name.push_back("rst_state");
    sb_exp.push_back(32'd0); sb_name.push_back("rst_flags");
    obs.push_back(32'(scl_o));
    obs.push_back(32'(sda_o));
    obs.push_back(32'({scl_posedge_o, scl_negedge_o, start_det_o, rstart_det_o, stop_det_o}));
    obs.push_back(32'(bus_state_o));
    obs.push_back(32'({bus_free_o, bus_available_o, bus_idle_o}));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    bit          dpat[23]  = '{1,1,1,1,0,0,1,1,1,1,1,1,0,0,0,1,1,1,1,1,1,1,1};
    bit          clean[23] = '{1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,1,1,1,1,1,1,1,1};
    logic [31:0] e;
    string       nm;
    logic [31:0] o;
    tg = 8'd3; en = 1'b0;
    do_reset();
    for (int j = 0; j < 23; j++) begin
      sda = dpat[j];
      sb_exp.push_back((j < 4) ? 32'd1 : 32'(clean[j-4]));
      sb_name.push_back($sformatf("glitch_sda_o[%0d]", j));
      sb_exp.push_back(32'd0);
      sb_name.push_back($sformatf("glitch_scl_edges[%0d]", j));
      tick();
      for (int k = 0; k < 2; k++) begin
        o = (k == 0) ? 32'(sda_o) : 32'({scl_posedge_o, scl_negedge_o});
        e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
        if (o !== e) begin
          n_err++; $display("FAIL %s: got %0h expected %0h", nm, o, e);
        end
      end
    end
  endtask

  task automatic test_start_stop();
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    int          f_free = 0;
    int          f_avail = 0;
    int          f_idle = 0;
    tg = 8'd1; tf = 20'd10; ta = 20'd20; ti = 20'd30; en = 1'b1;
    do_reset();
    tick(); tick(); tick();
    sda = 1'b0;
    tick(); tick(); tick();
    sb_exp.push_back(32'd0); sb_name.push_back("ss_sda_o_fell");
    sb_exp.push_back(32'd0); sb_name.push_back("ss_start_early");
    obs.push_back(32'(sda_o)); obs.push_back(32'(start_det_o));
    tick();
    sb_exp.push_back(32'd1); sb_name.push_back("ss_start_pulse");
    sb_exp.push_back(32'd0); sb_name.push_back("ss_rstart_quiet");
    sb_exp.push_back(SBusy); sb_name.push_back("ss_state_busy");
    obs.push_back(32'(start_det_o)); obs.push_back(32'(rstart_det_o));
    obs.push_back(32'(bus_state_o));
    tick();
    sb_exp.push_back(32'd0); sb_name.push_back("ss_start_one_cycle");
    obs.push_back(32'(start_det_o));
    scl = 1'b0;
    repeat (6) tick();
    scl = 1'b1;
    repeat (6) tick();
    sda = 1'b1;
    tick(); tick(); tick();
    sb_exp.push_back(32'd0); sb_name.push_back("ss_stop_early");
    obs.push_back(32'(stop_det_o));
    tick();
    sb_exp.push_back(32'd1); sb_name.push_back("ss_stop_pulse");
    sb_exp.push_back(SWait); sb_name.push_back("ss_state_waitfree");
    obs.push_back(32'(stop_det_o)); obs.push_back(32'(bus_state_o));
    sb_exp.push_back(32'd11); sb_name.push_back("ss_free_cycle");
    sb_exp.push_back(32'd21); sb_name.push_back("ss_avail_cycle");
    sb_exp.push_back(32'd31); sb_name.push_back("ss_idle_cycle");
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus_free_o && f_free == 0) f_free = c;
      if (bus_available_o && f_avail == 0) f_avail = c;
      if (bus_idle_o && f_idle == 0) f_idle = c;
    end
    obs.push_back(32'(f_free)); obs.push_back(32'(f_avail)); obs.push_back(32'(f_idle));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
  endtask

  task automatic test_rstart();
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    tg = 8'd1; tf = 20'd10; ta = 20'd20; ti = 20'd30; en = 1'b1;
    do_reset();
    sda = 1'b0;
    repeat (5) tick();
    scl = 1'b0;
    repeat (6) tick();
    sda = 1'b1;
    repeat (6) tick();
    scl = 1'b1;
    repeat (6) tick();
    sda = 1'b0;
    tick(); tick(); tick();
    sb_exp.push_back(32'd0); sb_name.push_back("rs_rstart_early");
    obs.push_back(32'(rstart_det_o));
    tick();
    sb_exp.push_back(32'd1); sb_name.push_back("rs_rstart_pulse");
    sb_exp.push_back(32'd0); sb_name.push_back("rs_start_quiet");
    sb_exp.push_back(SBusy); sb_name.push_back("rs_state_busy");
    obs.push_back(32'(rstart_det_o)); obs.push_back(32'(start_det_o));
    obs.push_back(32'(bus_state_o));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    logic        reached = 1'b0;
    tg = 8'd1; tf = 20'd5; ta = 20'd1000; ti = 20'd2000; en = 1'b1;
    do_reset();
    for (int c = 0; c < 50 && !reached; c++) begin
      tick();
      if (bus_state_o == 3'd2) reached = 1'b1;
    end
    sb_exp.push_back(32'd1); sb_name.push_back("sc_reached_free");
    obs.push_back(32'(reached));
    scl = 1'b0; sda = 1'b0;
    tick(); tick(); tick();
    sb_exp.push_back(32'd0); sb_name.push_back("sc_lines_low");
    obs.push_back(32'({scl_o, sda_o}));
    tick();
    sb_exp.push_back(32'd1); sb_name.push_back("sc_negedge");
    sb_exp.push_back(32'd0); sb_name.push_back("sc_no_start");
    sb_exp.push_back(SBusy); sb_name.push_back("sc_state_busy");
    obs.push_back(32'(scl_negedge_o)); obs.push_back(32'(start_det_o));
    obs.push_back(32'(bus_state_o));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    logic        reached = 1'b0;
    int          f_free = 0;
    tg = 8'd1; tf = 20'd10; ta = 20'd20; ti = 20'd22; en = 1'b1;
    do_reset();
    for (int c = 0; c < 60 && !reached; c++) begin
      tick();
      if (bus_idle_o) reached = 1'b1;
    end
    tick(); tick();
    sb_exp.push_back(32'd1); sb_name.push_back("rm_reached_idle");
    obs.push_back(32'(reached));
    rst = 1'b1;
    #1;
    sb_exp.push_back(SWait); sb_name.push_back("rm_state");
    sb_exp.push_back(32'd0); sb_name.push_back("rm_flags");
    sb_exp.push_back(32'd0); sb_name.push_back("rm_pulses");
    sb_exp.push_back(32'd3); sb_name.push_back("rm_lines");
    obs.push_back(32'(bus_state_o));
    obs.push_back(32'({bus_free_o, bus_available_o, bus_idle_o}));
    obs.push_back(32'({scl_posedge_o, scl_negedge_o, start_det_o, rstart_det_o, stop_det_o}));
    obs.push_back(32'({scl_o, sda_o}));
    rst = 1'b0;
    sb_exp.push_back(32'd11); sb_name.push_back("rm_free_requalify");
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus_free_o && f_free == 0) f_free = c;
    end
    obs.push_back(32'(f_free));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
  endtask

  task automatic test_enable_low();
    bit          pscl[6] = '{1, 0, 0, 1, 1, 1};
    bit          psda[6] = '{0, 0, 1, 1, 0, 1};
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    logic        cond_seen = 1'b0;
    logic        bad_state = 1'b0;
    logic        neg_seen  = 1'b0;
    int          f_free = 0;
    tg = 8'd1; tf = 20'd0; ta = 20'd0; ti = 20'd0; en = 1'b0;
    do_reset();
    for (int p = 0; p < 6; p++) begin
      scl = pscl[p]; sda = psda[p];
      repeat (4) begin
        tick();
        if (start_det_o || rstart_det_o || stop_det_o) cond_seen = 1'b1;
        if (bus_state_o != 3'd1 || bus_free_o) bad_state = 1'b1;
        if (scl_negedge_o) neg_seen = 1'b1;
      end
      sb_exp.push_back(32'({pscl[p], psda[p]}));
      sb_name.push_back($sformatf("en_lines_track[%0d]", p));
      obs.push_back(32'({scl_o, sda_o}));
    end
    sb_exp.push_back(32'd0); sb_name.push_back("en_no_conditions");
    sb_exp.push_back(32'd0); sb_name.push_back("en_held_waitfree");
    sb_exp.push_back(32'd1); sb_name.push_back("en_negedge_live");
    obs.push_back(32'(cond_seen)); obs.push_back(32'(bad_state));
    obs.push_back(32'(neg_seen));
    tf = 20'd10; ta = 20'd20; ti = 20'd30;
    en = 1'b1;
    sb_exp.push_back(32'd11); sb_name.push_back("en_count_from_zero");
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus_free_o && f_free == 0) f_free = c;
    end
    obs.push_back(32'(f_free));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
  endtask

  task automatic test_zero_thresholds();
    logic [31:0] obs[$];
    logic [31:0] e;
    string       nm;
    tg = 8'd0; tf = 20'd0; ta = 20'd0; ti = 20'd0; en = 1'b1;
    do_reset();
    sb_exp.push_back(SWait);  sb_name.push_back("z_state0");
    sb_exp.push_back(SFree);  sb_name.push_back("z_state1");
    sb_exp.push_back(SAvail); sb_name.push_back("z_state2");
    sb_exp.push_back(SIdle);  sb_name.push_back("z_state3");
    obs.push_back(32'(bus_state_o));
    for (int c = 0; c < 3; c++) begin
      tick();
      obs.push_back(32'(bus_state_o));
    end
    // t_glitch_i = 0 behaves as 1: three-cycle pin-to-output latency.
    sda = 1'b0;
    tick(); tick();
    sb_exp.push_back(32'd1); sb_name.push_back("z_glitch0_before");
    obs.push_back(32'(sda_o));
    tick();
    sb_exp.push_back(32'd0); sb_name.push_back("z_glitch0_after");
    obs.push_back(32'(sda_o));
    for (int i = 0; i < obs.size(); i++) begin
      e = sb_exp.pop_front(); nm = sb_name.pop_front(); n_vec++;
      if (obs[i] !== e) begin
        n_err++; $display("FAIL %s: got %0h expected %0h", nm, obs[i], e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; scl = 1'b1; sda = 1'b1;
    tg = 8'd1; tf = '0; ta = '0; ti = '0;
    test_reset();
    test_glitch();
    test_start_stop();
    test_rstart();
    test_same_cycle();
    test_reset_mid();
    test_enable_low();
    test_zero_thresholds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
